ysyx_25040109_axi_arbiter: RTL

YSYX_25040109_AXI_ARBITER -- requirements
Module: ysyx_25040109_axi_arbiter

---
 rtl/ysyx_25040109_axi_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040109_axi_arbiter.sv
// rtl/ysyx_25040109_axi_arbiter.sv - IFU/LSU read arbiter with LSU write pass-through to one upstream AXI port
// Define YSYX_25040109_ARB_RR_EN for round-robin on read ties; otherwise the LSU wins ties.
module ysyx_25040109_axi_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arid,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic [3:0]  m0_rid,
    output logic        m0_rlast,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arid,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic [3:0]  m1_rid,
    output logic        m1_rlast,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_awaddr,
    input  logic [3:0]  m1_awid,
    input  logic [7:0]  m1_awlen,
    input  logic [2:0]  m1_awsize,
    input  logic [1:0]  m1_awburst,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    output logic [1:0]  m1_bresp,
    output logic [3:0]  m1_bid,
    output logic        out_arvalid,
    input  logic        out_arready,
    output logic [31:0] out_araddr,
    output logic [3:0]  out_arid,
    output logic [7:0]  out_arlen,
    output logic [2:0]  out_arsize,
    output logic [1:0]  out_arburst,
    input  logic        out_rvalid,
    output logic        out_rready,
    input  logic [31:0] out_rdata,
    input  logic [1:0]  out_rresp,
    input  logic [3:0]  out_rid,
    input  logic        out_rlast,
    output logic        out_awvalid,
    input  logic        out_awready,
    output logic [31:0] out_awaddr,
    output logic [3:0]  out_awid,
    output logic [7:0]  out_awlen,
    output logic [2:0]  out_awsize,
    output logic [1:0]  out_awburst,
    output logic        out_wvalid,
    input  logic        out_wready,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wstrb,
    output logic        out_wlast,
    input  logic        out_bvalid,
    output logic        out_bready,
    input  logic [1:0]  out_bresp,
    input  logic [3:0]  out_bid
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    r_state_t state, state_next;
    logic     grant, grant_next, pick;
    logic     wr_busy;
    logic     m0_elig, m1_elig, sel_arvalid, sel_rready, ar_fire, r_done;

    // LSU reads wait for an outstanding write so a read can never overtake it.
    assign m0_elig     = m0_arvalid;
    assign m1_elig     = m1_arvalid && !wr_busy;
    assign sel_arvalid = grant ? m1_arvalid : m0_arvalid;
    assign sel_rready  = grant ? m1_rready : m0_rready;
    assign ar_fire     = (state == R_ADDR) && sel_arvalid && out_arready;
    assign r_done      = (state == R_DATA) && out_rvalid && sel_rready && out_rlast;

`ifdef YSYX_25040109_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (r_done)
            last_grant <= grant;
    end

    assign pick = (m0_elig && m1_elig) ? ~last_grant : m1_elig;
`else
    assign pick = m1_elig;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= R_IDLE;
            grant   <= 1'b0;
            wr_busy <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (out_awvalid && out_awready)
                wr_busy <= 1'b1;
            else if (out_bvalid && out_bready)
                wr_busy <= 1'b0;
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        out_arvalid = 1'b0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        out_rready  = 1'b0;
        case (state)
            R_IDLE: begin
                if (m0_elig || m1_elig) begin
                    state_next = R_ADDR;
                    grant_next = pick;
                end
            end
            R_ADDR: begin
                out_arvalid = sel_arvalid;
                m0_arready  = !grant && out_arready;
                m1_arready  = grant && out_arready;
                if (ar_fire)
                    state_next = R_DATA;
            end
            R_DATA: begin
                m0_rvalid  = !grant && out_rvalid;
                m1_rvalid  = grant && out_rvalid;
                out_rready = sel_rready;
                if (r_done)
                    state_next = R_IDLE;
            end
            default: state_next = R_IDLE;
        endcase
    end

    assign out_araddr  = grant ? m1_araddr : m0_araddr;
    assign out_arid    = grant ? m1_arid : m0_arid;
    assign out_arlen   = grant ? m1_arlen : m0_arlen;
    assign out_arsize  = grant ? m1_arsize : m0_arsize;
    assign out_arburst = grant ? m1_arburst : m0_arburst;

    assign m0_rdata = out_rdata;
    assign m0_rresp = out_rresp;
    assign m0_rid   = out_rid;
    assign m0_rlast = out_rlast;
    assign m1_rdata = out_rdata;
    assign m1_rresp = out_rresp;
    assign m1_rid   = out_rid;
    assign m1_rlast = out_rlast;

    assign out_awvalid = m1_awvalid;
    assign m1_awready  = out_awready;
    assign out_awaddr  = m1_awaddr;
    assign out_awid    = m1_awid;
    assign out_awlen   = m1_awlen;
    assign out_awsize  = m1_awsize;
    assign out_awburst = m1_awburst;
    assign out_wvalid  = m1_wvalid;
    assign m1_wready   = out_wready;
    assign out_wdata   = m1_wdata;
    assign out_wstrb   = m1_wstrb;
    assign out_wlast   = m1_wlast;
    assign m1_bvalid   = out_bvalid;
    assign out_bready  = m1_bready;
    assign m1_bresp    = out_bresp;
    assign m1_bid      = out_bid;

endmodule
